// File: rtl/seq_divider.sv
// Restoring divider for unsigned WIDTH-bit operands, one quotient bit per clock, START/BUSY/DONE handshake.
// Optional macro DIV_POW2_BYPASS_EN: power-of-two divisors finish in one cycle via shift/mask.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DI,
  input  logic [WIDTH-1:0] DV,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The partial remainder stays below the divisor, so only the WIDTH+1-bit shifted trial needs the extra bit.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_reg};
    rem_next  = rem_shift[WIDTH-1:0];
    quo_next  = {quo_reg[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end

`ifdef DIV_POW2_BYPASS_EN
  logic          pow2;
  logic [CW-1:0] shamt;

  always_comb begin
    pow2  = (DV != '0) && ((DV & (DV - WIDTH'(1))) == '0);
    shamt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (DV[i]) shamt = CW'(i);
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      DZ      <= 1'b0;
      dvd_reg <= '0;
      dvs_reg <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            dvd_reg <= DI;
            dvs_reg <= DV;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt     <= '0;
            if (DV == '0) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              DZ    <= 1'b1;
              Q     <= '1;
              R     <= DI;
`ifdef DIV_POW2_BYPASS_EN
            end else if (pow2) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              DZ    <= 1'b0;
              Q     <= DI >> shamt;
              R     <= DI & (DV - WIDTH'(1));
`endif
            end else begin
              // DZ is cleared at completion so the previous result stays intact during RUN.
              state <= RUN;
              BUSY  <= 1'b1;
              DONE  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            DONE  <= 1'b0;
          end
        end
        RUN: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            DZ    <= 1'b0;
            Q     <= quo_next;
            R     <= rem_next;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results and DONE cycle, a monitor pops and compares.
// Honours DIV_POW2_BYPASS_EN when computing expected latency of power-of-two divisors.
module tb_seq_divider;

  localparam int WIDTH = 8;
`ifdef DIV_POW2_BYPASS_EN
  localparam int POW_LAT = 0;
`else
  localparam int POW_LAT = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [WIDTH-1:0] DI = '0;
  logic [WIDTH-1:0] DV = '0;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DZ;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               done_cyc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DI(DI), .DV(DV),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DZ(DZ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got DONE at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_q"}, int'(Q), int'(e.q));
        checkOutput({e.name, "_r"}, int'(R), int'(e.r));
        checkOutput({e.name, "_dz"}, int'(DZ), int'(e.dz));
        checkOutput({e.name, "_cycle"}, cyc, e.done_cyc);
        checkOutput({e.name, "_busy_low"}, int'(BUSY), 0);
      end
    end
  end

  task automatic pushExp(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic dz,
                         input int done_cyc, input string name);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = dz;
    e.done_cyc = done_cyc;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge CLK);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Called at posedge+1; the next edge samples START.
  task automatic applyStimulus(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dv,
                               input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                               input logic dz, input int lat, input string name);
    START = 1'b1;
    DI = di;
    DV = dv;
    pushExp(q, r, dz, cyc + 1 + lat, name);
    @(posedge CLK);
    #1;
    START = 1'b0;
    DI = ~di;
    DV = ~dv;
    if (lat > 0) checkOutput({name, "_busy_run"}, int'(BUSY), 1);
    waitDone(name);
  endtask

  initial begin
    int n;
    #1;
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_done", int'(DONE), 0);
    checkOutput("reset_q", int'(Q), 0);
    checkOutput("reset_r", int'(R), 0);
    checkOutput("reset_dz", int'(DZ), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, WIDTH, "d100_7");
    applyStimulus(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, WIDTH, "d3_200");
    applyStimulus(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, POW_LAT, "d255_1");
    applyStimulus(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, "d5_0");
    applyStimulus(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, WIDTH, "d9_3");

    // START raised mid-RUN must be ignored, then honoured in the DONE cycle with no idle gap.
    n = cyc;
    START = 1'b1;
    DI = 8'd200;
    DV = 8'd9;
    pushExp(8'd22, 8'd2, 1'b0, n + 1 + WIDTH, "d200_9");
    @(posedge CLK);
    #1;
    START = 1'b0;
    DI = 8'd10;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    START = 1'b1;
    DI = 8'd10;
    DV = 8'd9;
    pushExp(8'd1, 8'd1, 1'b0, n + 2 + 2 * WIDTH, "b2b_10_9");
    while (cyc < n + 2 + WIDTH) begin
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    checkOutput("b2b_busy_no_gap", int'(BUSY), 1);
    waitDone("b2b");

    // Abort after four iterations: outputs clear at once and no DONE follows.
    START = 1'b1;
    DI = 8'd77;
    DV = 8'd5;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    #1;
    checkOutput("abort_busy", int'(BUSY), 0);
    checkOutput("abort_done", int'(DONE), 0);
    checkOutput("abort_q", int'(Q), 0);
    checkOutput("abort_r", int'(R), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, WIDTH, "d77_5");

    applyStimulus(8'd200, 8'd8, 8'd25, 8'd0, 1'b0, POW_LAT, "d200_8");
    applyStimulus(8'd254, 8'd16, 8'd15, 8'd14, 1'b0, POW_LAT, "d254_16");
    applyStimulus(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, WIDTH, "d255_255");
    applyStimulus(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, WIDTH, "d0_5");
    applyStimulus(8'd128, 8'd0, 8'hFF, 8'd128, 1'b1, 0, "d128_0");

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
